cjb_param_hwstack_v: RTL and testbench
======================================

Name: cjb_param_hwstack_v

Overview:
- Parametrised hardware LIFO stack for the RISC data path's write-back-bus stack source.
- Generalises the fixed 4-location 8-bit stack in three ways:
  - WIDTH and DEPTH are parameters.
  - Two overflow modes are selectable: reject, or circular overwrite of the oldest entry.
  - Full/empty status, an occupancy count, and sticky overflow/underflow error flags are exported for the control unit.
- Push data comes from IB2. dout feeds the ipstk mux.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 4, number of entries (>=2; need not be a power of 2).
- OVF_MODE, 0, behaviour on push when full:
  - 0 = reject the push.
  - 1 = overwrite the oldest entry (circular).

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- push  in  1  push din this cycle.
- pop  in  1  pop the top entry this cycle.
- clr_err  in  1  clear the sticky error flags.
- din  in  WIDTH  data to push.
- dout  out  WIDTH  current top of stack (combinational from storage); 0 when empty.
- count  out  $clog2(DEPTH+1)  number of valid entries, 0..DEPTH.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- ovf_err  out  1  sticky: a push was attempted while full.
- unf_err  out  1  sticky: a pop was attempted while empty.

Behaviour:
- Storage and pointers:
  - Storage is mem[0..DEPTH-1].
  - wp = next-free index. It wraps modulo DEPTH: DEPTH-1 -> 0 on increment, 0 -> DEPTH-1 on decrement.
  - count = valid entries. Top index = (wp-1) mod DEPTH.
- Reset (Reset=0, asynchronous): wp=0, count=0, all mem entries=0, ovf_err=0, unf_err=0. Resulting outputs: dout=0, empty=1, full=0. Reset asserted mid-operation discards all contents immediately.
- Idle (push=0, pop=0): no state change.
- Push only, not full: mem[wp]<=din, wp++, count++. dout=din from the next cycle.
- Push only, full, OVF_MODE=0: storage, wp and count unchanged; ovf_err<=1.
- Push only, full, OVF_MODE=1:
  - mem[wp]<=din; wp is the oldest slot when full, so the oldest entry is overwritten.
  - wp++; count stays DEPTH; ovf_err<=1.
- Pop only, not empty: wp--, count--. The popped entry is not cleared. dout shows the new top, or 0 if empty.
- Pop only, empty: no state change; unf_err<=1.
- Push and pop together, not empty (including full):
  - Replace top: mem[(wp-1) mod DEPTH]<=din.
  - wp and count unchanged; no error in either mode.
- Push and pop together, empty: behaves as push only; no unf_err.
- Error flags:
  - clr_err=1 clears both flags at the next edge.
  - If an error event occurs in the same cycle as clr_err, the set wins.
  - Flags stay set until cleared or reset.
- Timing: single-cycle operation, one push/pop per clock, no stall. count/empty/full are registered or derived from registered count, so they are valid one cycle after the operation.
- Arithmetic:
  - count width is $clog2(DEPTH+1).
  - Pointer width is max(1,$clog2(DEPTH)).
  - Modulo wrap uses an explicit compare against DEPTH-1 or 0, so non-power-of-2 DEPTH is handled.

Decomposition:
- Shared package cjb_stack_pkg:
  - OVF_REJECT=0, OVF_WRAP=1.
  - A width helper function for the count/pointer widths.
- One natural sub-module: cjb_modn_updn_ptr_v (#DEPTH), a modulo-DEPTH up/down pointer with inc/dec inputs. It is instantiated once for wp. Storage, count and flags stay in the top module.

Test Plan (WIDTH=8, DEPTH=4 unless noted):
- Reset release, then push 0x11,0x22,0x33,0x44 -> dout=0x44, count=4, full=1, empty=0, ovf_err=0.
- Then pop x4 -> dout sequence 0x33,0x22,0x11,0x00; empty=1. A fifth pop -> unf_err=1, count=0. clr_err -> unf_err=0.
- OVF_MODE=0 with stack full of 0x11..0x44, push 0x55 -> ovf_err=1, count=4, dout=0x44. Pops return 0x44,0x33,0x22,0x11.
- OVF_MODE=1 with stack full of 0x11..0x44, push 0x55 -> ovf_err=1, count=4, dout=0x55. Pops return 0x55,0x44,0x33,0x22 (0x11 lost).
- Simultaneous push+pop:
  - Stack [0x11,0x22], push+pop din=0x99 -> count=2, dout=0x99, no error.
  - Empty stack, push+pop din=0x77 -> count=1, dout=0x77, unf_err=0.
- Async reset asserted mid-sequence between clock edges (stack holds 3 entries) -> count=0, empty=1, dout=0 immediately without a clock edge.
- Additional run with DEPTH=5: fill 5 entries, then wrap push (OVF_MODE=1) -> correct modulo-5 wrap; pops return newest-first.

Source files
------------

// File: rtl/cjb_stack_pkg.sv
// Shared definitions for the parametrised hardware stack: overflow mode codes
// and the width helpers used to size the occupancy count and the pointer.
package cjb_stack_pkg;

  // Behaviour selected when a push arrives while the stack is full
  localparam int OVF_REJECT = 0;
  localparam int OVF_WRAP   = 1;

  // Bits needed to hold an occupancy value from 0 up to and including depth
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Bits needed to index depth entries, never less than one bit
  function automatic int ptr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/cjb_modn_updn_ptr_v.sv
// Modulo-DEPTH up/down pointer. Increments and decrements wrap with explicit
// compares against the end values, so DEPTH does not have to be a power of 2.
// Also exposes the value one below the pointer (the stack top index).
module cjb_modn_updn_ptr_v
  import cjb_stack_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW   = ptr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          dec,
  output logic [PW-1:0] ptr,
  output logic [PW-1:0] ptr_prev
);

  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  // Next pointer value; inc and dec together cancel out
  always_comb begin
    ptr_d = ptr_q;
    if (inc && !dec) begin
      ptr_d = (ptr_q == LAST) ? '0 : ptr_q + PW'(1);
    end else if (dec && !inc) begin
      ptr_d = (ptr_q == '0) ? LAST : ptr_q - PW'(1);
    end
  end

  // Index just below the pointer, wrapping from 0 to the last slot
  always_comb begin
    ptr_prev = (ptr_q == '0) ? LAST : ptr_q - PW'(1);
  end

  // Pointer register, cleared by the asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/cjb_param_hwstack_v.sv
// Parametrised LIFO stack feeding the write-back-bus stack source. Push data
// comes from IB2 and the top of stack drives the ipstk mux. Exports occupancy,
// full/empty and sticky overflow/underflow flags for the control unit.
module cjb_param_hwstack_v
  import cjb_stack_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int OVF_MODE = OVF_REJECT,
  localparam int CW      = cnt_width(DEPTH),
  localparam int PW      = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             clr_err,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             ovf_err,
  output logic             unf_err
);

  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             ovf_err_q;
  logic             ovf_err_d;
  logic             unf_err_q;
  logic             unf_err_d;

  logic [PW-1:0]    wp;
  logic [PW-1:0]    top_idx;
  logic             wp_inc;
  logic             wp_dec;
  logic             mem_we;
  logic [PW-1:0]    mem_waddr;
  logic             is_empty;
  logic             is_full;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CNT_FULL);

  // Write pointer: wp is the next free slot, top_idx the current top
  cjb_modn_updn_ptr_v #(
    .DEPTH (DEPTH)
  ) u_wp (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (wp_inc),
    .dec      (wp_dec),
    .ptr      (wp),
    .ptr_prev (top_idx)
  );

  // Decode the push/pop request into pointer moves, a storage write,
  // the next occupancy and the next error flags (an error set beats clr_err)
  always_comb begin
    wp_inc    = 1'b0;
    wp_dec    = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = wp;
    count_d   = count_q;
    ovf_err_d = clr_err ? 1'b0 : ovf_err_q;
    unf_err_d = clr_err ? 1'b0 : unf_err_q;

    if (push && pop && !is_empty) begin
      mem_we    = 1'b1;
      mem_waddr = top_idx;
    end else if (push) begin
      if (!is_full) begin
        mem_we  = 1'b1;
        wp_inc  = 1'b1;
        count_d = count_q + CW'(1);
      end else begin
        ovf_err_d = 1'b1;
        if (OVF_MODE == OVF_WRAP) begin
          mem_we = 1'b1;
          wp_inc = 1'b1;
        end
      end
    end else if (pop) begin
      if (!is_empty) begin
        wp_dec  = 1'b1;
        count_d = count_q - CW'(1);
      end else begin
        unf_err_d = 1'b1;
      end
    end
  end

  // Storage next state: only the addressed entry changes on a write
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (mem_we) begin
      mem_d[mem_waddr] = din;
    end
  end

  // State registers; reset clears contents, occupancy and flags at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      count_q   <= '0;
      ovf_err_q <= 1'b0;
      unf_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      count_q   <= count_d;
      ovf_err_q <= ovf_err_d;
      unf_err_q <= unf_err_d;
    end
  end

  // Top of stack read straight from storage, forced to zero when empty
  always_comb begin
    dout = is_empty ? '0 : mem_q[top_idx];
  end

  assign count   = count_q;
  assign empty   = is_empty;
  assign full    = is_full;
  assign ovf_err = ovf_err_q;
  assign unf_err = unf_err_q;

endmodule

// File: tb/tb_cjb_param_hwstack_v.sv
// Directed bench for the parametrised stack. Three instances share stimulus:
// reject mode and wrap mode at DEPTH=4, and wrap mode at DEPTH=5.
module tb_cjb_param_hwstack_v;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] din = 8'h00;

  logic [7:0] d0_dout, d1_dout, d5_dout;
  logic [2:0] d0_count, d1_count, d5_count;
  logic       d0_empty, d1_empty, d5_empty;
  logic       d0_full, d1_full, d5_full;
  logic       d0_ovf, d1_ovf, d5_ovf;
  logic       d0_unf, d1_unf, d5_unf;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  // Reject mode, DEPTH=4
  cjb_param_hwstack_v #(.WIDTH(8), .DEPTH(4), .OVF_MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .clr_err(clr_err), .din(din),
    .dout(d0_dout), .count(d0_count), .empty(d0_empty), .full(d0_full),
    .ovf_err(d0_ovf), .unf_err(d0_unf)
  );

  // Wrap mode, DEPTH=4
  cjb_param_hwstack_v #(.WIDTH(8), .DEPTH(4), .OVF_MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .clr_err(clr_err), .din(din),
    .dout(d1_dout), .count(d1_count), .empty(d1_empty), .full(d1_full),
    .ovf_err(d1_ovf), .unf_err(d1_unf)
  );

  // Wrap mode, DEPTH=5 (non power of two)
  cjb_param_hwstack_v #(.WIDTH(8), .DEPTH(5), .OVF_MODE(1)) dut5 (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .clr_err(clr_err), .din(din),
    .dout(d5_dout), .count(d5_count), .empty(d5_empty), .full(d5_full),
    .ovf_err(d5_ovf), .unf_err(d5_unf)
  );

  // Drive one operation for one clock; outputs are settled 1 time unit after the edge
  task automatic cycle(input logic p_push, input logic p_pop, input logic p_clr, input logic [7:0] p_din);
    push = p_push;
    pop = p_pop;
    clr_err = p_clr;
    din = p_din;
    @(posedge clk);
    #1;
    push = 1'b0;
    pop = 1'b0;
    clr_err = 1'b0;
    din = 8'h00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    compared++; if (d0_dout !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_dout: got %h expected 00", d0_dout); end
    compared++; if (d0_count !== 3'd0) begin mismatched++; $display("[TB] FAIL reset_count: got %0d expected 0", d0_count); end
    compared++; if (d0_empty !== 1'b1 || d0_full !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_flags: got empty=%b full=%b expected 1 0", d0_empty, d0_full); end
    compared++; if (d0_ovf !== 1'b0 || d0_unf !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_err: got ovf=%b unf=%b expected 0 0", d0_ovf, d0_unf); end
    compared++; if (d5_count !== 3'd0 || d5_empty !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_d5: got count=%0d empty=%b expected 0 1", d5_count, d5_empty); end
  endtask

  task automatic test_fill_and_drain();
    logic [7:0] exp_after_pop [4] = '{8'h33, 8'h22, 8'h11, 8'h00};
    do_reset();
    cycle(1, 0, 0, 8'h11);
    compared++; if (d0_dout !== 8'h11 || d0_count !== 3'd1) begin mismatched++; $display("[TB] FAIL push1: got dout=%h count=%0d expected 11 1", d0_dout, d0_count); end
    cycle(1, 0, 0, 8'h22);
    cycle(1, 0, 0, 8'h33);
    cycle(1, 0, 0, 8'h44);
    compared++; if (d0_dout !== 8'h44) begin mismatched++; $display("[TB] FAIL fill_dout: got %h expected 44", d0_dout); end
    compared++; if (d0_count !== 3'd4) begin mismatched++; $display("[TB] FAIL fill_count: got %0d expected 4", d0_count); end
    compared++; if (d0_full !== 1'b1 || d0_empty !== 1'b0 || d0_ovf !== 1'b0) begin mismatched++; $display("[TB] FAIL fill_flags: got full=%b empty=%b ovf=%b expected 1 0 0", d0_full, d0_empty, d0_ovf); end
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1, 0, 8'h00);
      compared++; if (d0_dout !== exp_after_pop[i]) begin mismatched++; $display("[TB] FAIL drain_dout%0d: got %h expected %h", i, d0_dout, exp_after_pop[i]); end
    end
    compared++; if (d0_empty !== 1'b1 || d0_unf !== 1'b0) begin mismatched++; $display("[TB] FAIL drain_empty: got empty=%b unf=%b expected 1 0", d0_empty, d0_unf); end
    cycle(0, 1, 0, 8'h00);
    compared++; if (d0_unf !== 1'b1 || d0_count !== 3'd0) begin mismatched++; $display("[TB] FAIL underflow: got unf=%b count=%0d expected 1 0", d0_unf, d0_count); end
    cycle(0, 0, 0, 8'h00);
    compared++; if (d0_unf !== 1'b1) begin mismatched++; $display("[TB] FAIL unf_sticky: got %b expected 1", d0_unf); end
    cycle(0, 1, 1, 8'h00);
    compared++; if (d0_unf !== 1'b1) begin mismatched++; $display("[TB] FAIL unf_set_wins: got %b expected 1", d0_unf); end
    cycle(0, 0, 1, 8'h00);
    compared++; if (d0_unf !== 1'b0) begin mismatched++; $display("[TB] FAIL unf_clear: got %b expected 0", d0_unf); end
  endtask

  task automatic test_overflow_modes();
    logic [7:0] exp_rej [4] = '{8'h44, 8'h33, 8'h22, 8'h11};
    logic [7:0] exp_wrp [4] = '{8'h55, 8'h44, 8'h33, 8'h22};
    do_reset();
    cycle(1, 0, 0, 8'h11);
    cycle(1, 0, 0, 8'h22);
    cycle(1, 0, 0, 8'h33);
    cycle(1, 0, 0, 8'h44);
    cycle(1, 0, 0, 8'h55);
    compared++; if (d0_ovf !== 1'b1 || d0_count !== 3'd4 || d0_dout !== 8'h44) begin mismatched++; $display("[TB] FAIL ovf_reject: got ovf=%b count=%0d dout=%h expected 1 4 44", d0_ovf, d0_count, d0_dout); end
    compared++; if (d1_ovf !== 1'b1 || d1_count !== 3'd4 || d1_dout !== 8'h55) begin mismatched++; $display("[TB] FAIL ovf_wrap: got ovf=%b count=%0d dout=%h expected 1 4 55", d1_ovf, d1_count, d1_dout); end
    for (int i = 0; i < 4; i++) begin
      compared++; if (d0_dout !== exp_rej[i]) begin mismatched++; $display("[TB] FAIL rej_pop%0d: got %h expected %h", i, d0_dout, exp_rej[i]); end
      compared++; if (d1_dout !== exp_wrp[i]) begin mismatched++; $display("[TB] FAIL wrap_pop%0d: got %h expected %h", i, d1_dout, exp_wrp[i]); end
      cycle(0, 1, 0, 8'h00);
    end
    compared++; if (d0_empty !== 1'b1 || d1_empty !== 1'b1) begin mismatched++; $display("[TB] FAIL ovf_drained: got empty0=%b empty1=%b expected 1 1", d0_empty, d1_empty); end
    cycle(0, 0, 1, 8'h00);
    compared++; if (d0_ovf !== 1'b0 || d1_ovf !== 1'b0) begin mismatched++; $display("[TB] FAIL ovf_clear: got ovf0=%b ovf1=%b expected 0 0", d0_ovf, d1_ovf); end
  endtask

  task automatic test_push_pop();
    do_reset();
    cycle(1, 0, 0, 8'h11);
    cycle(1, 0, 0, 8'h22);
    cycle(1, 1, 0, 8'h99);
    compared++; if (d0_count !== 3'd2 || d0_dout !== 8'h99) begin mismatched++; $display("[TB] FAIL pp_replace: got count=%0d dout=%h expected 2 99", d0_count, d0_dout); end
    compared++; if (d0_ovf !== 1'b0 || d0_unf !== 1'b0) begin mismatched++; $display("[TB] FAIL pp_noerr: got ovf=%b unf=%b expected 0 0", d0_ovf, d0_unf); end
    cycle(0, 1, 0, 8'h00);
    compared++; if (d0_dout !== 8'h11) begin mismatched++; $display("[TB] FAIL pp_below: got %h expected 11", d0_dout); end
    cycle(1, 0, 0, 8'h22);
    cycle(1, 0, 0, 8'h33);
    cycle(1, 0, 0, 8'h44);
    cycle(1, 1, 0, 8'hAA);
    compared++; if (d0_count !== 3'd4 || d0_dout !== 8'hAA || d0_ovf !== 1'b0) begin mismatched++; $display("[TB] FAIL pp_full_rej: got count=%0d dout=%h ovf=%b expected 4 aa 0", d0_count, d0_dout, d0_ovf); end
    compared++; if (d1_count !== 3'd4 || d1_dout !== 8'hAA || d1_ovf !== 1'b0) begin mismatched++; $display("[TB] FAIL pp_full_wrap: got count=%0d dout=%h ovf=%b expected 4 aa 0", d1_count, d1_dout, d1_ovf); end
    do_reset();
    cycle(1, 1, 0, 8'h77);
    compared++; if (d0_count !== 3'd1 || d0_dout !== 8'h77 || d0_unf !== 1'b0) begin mismatched++; $display("[TB] FAIL pp_empty: got count=%0d dout=%h unf=%b expected 1 77 0", d0_count, d0_dout, d0_unf); end
  endtask

  task automatic test_async_reset();
    do_reset();
    cycle(1, 0, 0, 8'hA1);
    cycle(1, 0, 0, 8'hA2);
    cycle(1, 0, 0, 8'hA3);
    compared++; if (d0_count !== 3'd3) begin mismatched++; $display("[TB] FAIL ar_pre: got count=%0d expected 3", d0_count); end
    #2;
    rst_n = 1'b0;
    #1;
    compared++; if (d0_count !== 3'd0 || d0_empty !== 1'b1 || d0_dout !== 8'h00) begin mismatched++; $display("[TB] FAIL ar_immediate: got count=%0d empty=%b dout=%h expected 0 1 00", d0_count, d0_empty, d0_dout); end
    @(negedge clk);
    rst_n = 1'b1;
    compared++; if (d0_count !== 3'd0 || d0_dout !== 8'h00) begin mismatched++; $display("[TB] FAIL ar_held: got count=%0d dout=%h expected 0 00", d0_count, d0_dout); end
  endtask

  task automatic test_depth5_wrap();
    logic [7:0] exp_pop [5] = '{8'h06, 8'h05, 8'h04, 8'h03, 8'h02};
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      cycle(1, 0, 0, 8'(i));
    end
    compared++; if (d5_count !== 3'd5 || d5_full !== 1'b1 || d5_dout !== 8'h05) begin mismatched++; $display("[TB] FAIL d5_fill: got count=%0d full=%b dout=%h expected 5 1 05", d5_count, d5_full, d5_dout); end
    cycle(1, 0, 0, 8'h06);
    compared++; if (d5_count !== 3'd5 || d5_ovf !== 1'b1 || d5_dout !== 8'h06) begin mismatched++; $display("[TB] FAIL d5_wrap: got count=%0d ovf=%b dout=%h expected 5 1 06", d5_count, d5_ovf, d5_dout); end
    for (int i = 0; i < 5; i++) begin
      compared++; if (d5_dout !== exp_pop[i]) begin mismatched++; $display("[TB] FAIL d5_pop%0d: got %h expected %h", i, d5_dout, exp_pop[i]); end
      cycle(0, 1, 0, 8'h00);
    end
    compared++; if (d5_empty !== 1'b1 || d5_dout !== 8'h00) begin mismatched++; $display("[TB] FAIL d5_empty: got empty=%b dout=%h expected 1 00", d5_empty, d5_dout); end
  endtask

  initial begin
    test_reset();
    test_fill_and_drain();
    test_overflow_modes();
    test_push_pop();
    test_async_reset();
    test_depth5_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
